mem_arbiter: RTL
================

// Module: mem_arbiter
// PURPOSE
//  Shares one single-port synchronous RAM (registered address, 1-cycle read latency, rw=1 write)
//  between the processor's instruction-fetch port (read-only) and data-memory port (read/write).
//  Sits between processor ir_m_*/main_m_* and a unified RAM. Grants at most one access per cycle.
//  Data port has priority; a starvation guard bounds fetch delay. Requesters stall on !gnt.
// PARAMETERS
//  ADDR_W      12  address width
//  DATA_W      16  data width
//  STARVE_MAX  3   consecutive denied fetch cycles before fetch wins a conflict (legal 1..15)
// PORTS
//  clock      in   1       rising-edge clock, the only clock
//  reset_n    in   1       asynchronous, active-low reset
//  if_req     in   1       fetch request (held until granted)
//  if_addr    in   ADDR_W  fetch address
//  if_gnt     out  1       fetch issued to RAM this cycle
//  if_rvalid  out  1       if_rdata valid (cycle after if_gnt)
//  if_rdata   out  DATA_W  fetch read data
//  dm_req     in   1       data request (held until granted)
//  dm_rw      in   1       1=write, 0=read
//  dm_addr    in   ADDR_W  data address
//  dm_wdata   in   DATA_W  write data
//  dm_gnt     out  1       data access issued this cycle
//  dm_rvalid  out  1       dm_rdata valid (cycle after read grant; never for writes)
//  dm_rdata   out  DATA_W  data read data
//  m_addr     out  ADDR_W  RAM address
//  m_data     out  DATA_W  RAM write data
//  m_rw       out  1       RAM write enable
//  m_q        in   DATA_W  RAM read data (1 cycle after address)
// BEHAVIOUR
//  - Grant is combinational from req and starve state; RAM is driven the same cycle.
//  - Only dm_req: dm_gnt=1. Only if_req: if_gnt=1. Neither: no grant, m_rw=0, m_addr holds last.
//  - Both: dm wins unless starve_cnt==STARVE_MAX, then if wins. Never both gnt in one cycle.
//  - starve_cnt: +1 when if_req && !if_gnt (saturates at STARVE_MAX); cleared when if_gnt or !if_req.
//  - m_rw = dm_gnt & dm_rw; m_data = dm_wdata when dm write granted, else 0.
//  - FSM records access issued last cycle: IDLE, RD_IF, RD_DM, WR. Next state from this cycle's grant.
//    RD_IF -> if_rvalid=1; RD_DM -> dm_rvalid=1; WR/IDLE -> no rvalid.
//  - if_rdata = dm_rdata = m_q (pass-through); consumers qualify with rvalid.
//  - Back-to-back grants allowed every cycle; a write followed by a read of the same address
//    returns the new data (in-order single port).
//  - Reset (async, reset_n=0): FSM=IDLE, starve_cnt=0, rvalid both 0, gnt both 0, m_rw=0,
//    m_addr=0. Reset mid-read: pending rvalid is dropped, not delivered after release.
//  - First grant possible in the first cycle after reset_n rises.
// CONFIGURATION
//  MEM_ARB_STATS_EN defined: adds outputs stat_conflicts[15:0] (cycles with both req),
//  stat_if_stall[15:0] (cycles if_req && !if_gnt); both saturate at 16'hFFFF, reset to 0.
//  Not defined: ports and counters absent; arbitration identical.
// STRUCTURE
//  Package mem_arb_pkg: state enum (IDLE, RD_IF, RD_DM, WR), ADDR_W/DATA_W defaults,
//  STARVE_W=4 localparam.
//  Sub-module mem_arb_starve_cnt: saturating counter with inc/clr inputs, at_max output.
// TESTING
//  1. if_req=1 @0x010 only, m_q=0x1234 next cycle -> if_gnt=1, next cycle if_rvalid=1, if_rdata=0x1234.
//  2. dm write 0x005<-0xBEEF then dm read 0x005 -> m_rw=1 cycle 0, dm_rvalid=1 rdata=0xBEEF cycle 2.
//  3. Both req held 5 cycles, STARVE_MAX=3 -> dm_gnt cycles 0-2, if_gnt cycle 3, dm_gnt cycle 4.
//  4. if_req drops for one cycle after 2 denials -> starve_cnt clears; next conflict dm wins 3 more.
//  5. reset_n=0 one cycle after dm read grant -> dm_rvalid stays 0, all outputs at reset values.
//  6. MEM_ARB_STATS_EN, 4 conflict cycles -> stat_conflicts=4, stat_if_stall=3.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the fetch/data RAM arbiter.
// Optional statistics build: define MEM_ARB_STATS_EN.
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 12;
  localparam int DATA_W_DEF = 16;
  localparam int STARVE_W   = 4;

  typedef enum logic [1:0] {
    IDLE,
    RD_IF,
    RD_DM,
    WR
  } arb_state_e;

endpackage

// File: rtl/mem_arb_if.sv
// Requester + RAM bundle seen by the arbiter.
// slave: arbiter side; master: processor/RAM side.
interface mem_arb_if #(
  parameter int ADDR_W = mem_arb_pkg::ADDR_W_DEF,
  parameter int DATA_W = mem_arb_pkg::DATA_W_DEF
) ();

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              dm_req;
  logic              dm_rw;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_gnt;
  logic              dm_rvalid;
  logic [DATA_W-1:0] dm_rdata;

  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_data;
  logic              m_rw;
  logic [DATA_W-1:0] m_q;

  modport slave (
    input  if_req, if_addr,
    input  dm_req, dm_rw, dm_addr, dm_wdata,
    input  m_q,
    output if_gnt, if_rvalid, if_rdata,
    output dm_gnt, dm_rvalid, dm_rdata,
    output m_addr, m_data, m_rw
  );

  modport master (
    output if_req, if_addr,
    output dm_req, dm_rw, dm_addr, dm_wdata,
    output m_q,
    input  if_gnt, if_rvalid, if_rdata,
    input  dm_gnt, dm_rvalid, dm_rdata,
    input  m_addr, m_data, m_rw
  );

endinterface

// File: rtl/mem_arb_starve_cnt.sv
// Saturating count of consecutive denied fetch cycles.
// at_max tells the arbiter fetch must win the next conflict.
module mem_arb_starve_cnt
  import mem_arb_pkg::*;
#(
  parameter int MAX = 3
) (
  input  logic clock,
  input  logic reset_n,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  localparam logic [STARVE_W-1:0] MAX_C = STARVE_W'(MAX);

  logic [STARVE_W-1:0] cnt;

  // count denials, hold at MAX, clear on grant or drop
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && cnt != MAX_C) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign at_max = (cnt == MAX_C);

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter: data port first, fetch protected by starvation guard.
// Optional build MEM_ARB_STATS_EN adds conflict/stall counters.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STARVE_MAX = 3
) (
  input  logic        clock,
  input  logic        reset_n,
  mem_arb_if.slave    bus
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [15:0] stat_conflicts,
  output logic [15:0] stat_if_stall
`endif
);

  arb_state_e        state_q;
  arb_state_e        state_d;
  logic              if_gnt;
  logic              dm_gnt;
  logic              if_rvalid;
  logic              dm_rvalid;
  logic              at_max;
  logic              if_wait;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_d;

  mem_arb_starve_cnt #(
    .MAX (STARVE_MAX)
  ) u_starve (
    .clock   (clock),
    .reset_n (reset_n),
    .inc     (if_wait),
    .clr     (!if_wait),
    .at_max  (at_max)
  );

  // record which access went to the RAM this cycle
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  // grant, next access record and read-valid decode
  always_comb begin
    if_gnt    = 1'b0;
    dm_gnt    = 1'b0;
    state_d   = IDLE;
    if_rvalid = 1'b0;
    dm_rvalid = 1'b0;
    if (reset_n) begin
      if (bus.dm_req && !(bus.if_req && at_max)) begin
        dm_gnt = 1'b1;
      end else if (bus.if_req) begin
        if_gnt = 1'b1;
      end
    end
    unique case (1'b1)
      if_gnt:                 state_d = RD_IF;
      (dm_gnt && bus.dm_rw):  state_d = WR;
      (dm_gnt && !bus.dm_rw): state_d = RD_DM;
      default:                state_d = IDLE;
    endcase
    unique case (state_q)
      RD_IF:   if_rvalid = 1'b1;
      RD_DM:   dm_rvalid = 1'b1;
      default: ;
    endcase
  end

  assign if_wait = bus.if_req && !if_gnt;
  assign addr_d  = if_gnt ? bus.if_addr :
                   dm_gnt ? bus.dm_addr : addr_q;

  assign bus.if_gnt    = if_gnt;
  assign bus.dm_gnt    = dm_gnt;
  assign bus.if_rvalid = if_rvalid;
  assign bus.dm_rvalid = dm_rvalid;
  assign bus.if_rdata  = bus.m_q;
  assign bus.dm_rdata  = bus.m_q;
  assign bus.m_addr    = addr_d;
  assign bus.m_rw      = dm_gnt && bus.dm_rw;
  assign bus.m_data    = (dm_gnt && bus.dm_rw) ? bus.dm_wdata : '0;

`ifdef MEM_ARB_STATS_EN
  // saturating conflict and fetch-stall counters
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stat_conflicts <= '0;
      stat_if_stall  <= '0;
    end else begin
      if (bus.if_req && bus.dm_req && stat_conflicts != 16'hFFFF)
        stat_conflicts <= stat_conflicts + 16'd1;
      if (if_wait && stat_if_stall != 16'hFFFF)
        stat_if_stall <= stat_if_stall + 16'd1;
    end
  end
`endif

endmodule
